// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO constants and parameter helpers.
// Used by param_sync_fifo and dual_clock_fifo so that both FIFOs agree on
// default geometry and on how the address width is derived.
package fifo_pkg;
   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int DEFAULT_FIFO_DEPTH = 16;
   function automatic bit is_pow2(input int n);
      return n >= 2 && (n & (n - 1)) == 0;
   endfunction
   function automatic int addr_width(input int n);
      return $clog2(n);
   endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DATA_WIDTH x FIFO_DEPTH storage, synchronous write, asynchronous read.
// Ports: clk_i clock; we_i write enable; waddr_i/wdata_i write address/data;
//        raddr_i read address; rdata_o combinational read data.
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
   parameter int AW = addr_width(FIFO_DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [AW-1:0]         waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]         raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   always_ff @(posedge clk_i)
      if (we_i) mem_q[waddr_i] <= wdata_i;
   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock circular-buffer FIFO with occupancy, programmable
// almost flags, sticky error flags and registered-read or FWFT output.
// Ports: clk1 clock; reset sync active-high; data_in/write_en write side;
//        read_en pop; clear_err clears sticky errors; data_out/valid read side;
//        full/empty/almost_full/almost_empty/count occupancy; overflow/underflow
//        sticky error flags.
module param_sync_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
   parameter int FIFO_DEPTH    = DEFAULT_FIFO_DEPTH,
   parameter int AFULL_THRESH  = 12,
   parameter int AEMPTY_THRESH = 4,
   parameter bit FWFT          = 1'b0
) (
   input  logic                                clk1,
   input  logic                                reset,
   input  logic [DATA_WIDTH-1:0]               data_in,
   input  logic                                write_en,
   input  logic                                read_en,
   input  logic                                clear_err,
   output logic [DATA_WIDTH-1:0]               data_out,
   output logic                                valid,
   output logic                                full,
   output logic                                empty,
   output logic                                almost_full,
   output logic                                almost_empty,
   output logic [addr_width(FIFO_DEPTH):0]     count,
   output logic                                overflow,
   output logic                                underflow
);
   localparam int AW = addr_width(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
   localparam logic [AW:0] AFULL_C  = (AW + 1)'(AFULL_THRESH);
   localparam logic [AW:0] AEMPTY_C = (AW + 1)'(AEMPTY_THRESH);

   if (!is_pow2(FIFO_DEPTH)) begin : g_depth_chk
      $error("FIFO_DEPTH must be a power of 2 and >= 2");
   end
   if (AFULL_THRESH < 1 || AFULL_THRESH > FIFO_DEPTH ||
       AEMPTY_THRESH < 0 || AEMPTY_THRESH > FIFO_DEPTH - 1) begin : g_thresh_chk
      $error("almost-full/almost-empty threshold out of range");
   end

   logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]           count_q, count_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d, ram_rdata;
   logic                  valid_q, valid_d, ovf_q, ovf_d, udf_q, udf_d;
   logic                  wr_acc, rd_acc;

   // Flags come from the registered count, so a full FIFO rejects a write even
   // when a read is accepted in the same cycle.
   assign full         = count_q == DEPTH_C;
   assign empty        = count_q == '0;
   assign almost_full  = count_q >= AFULL_C;
   assign almost_empty = count_q <= AEMPTY_C;
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;
   assign wr_acc       = write_en & ~full;
   assign rd_acc       = read_en & ~empty;

   fifo_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .FIFO_DEPTH(FIFO_DEPTH),
      .AW        (AW)
   ) u_ram (
      .clk_i  (clk1),
      .we_i   (wr_acc & ~reset),
      .waddr_i(wr_ptr_q),
      .wdata_i(data_in),
      .raddr_i(rd_ptr_q),
      .rdata_o(ram_rdata)
   );

   always_comb begin
      wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = (wr_acc & ~rd_acc) ? count_q + 1'b1 :
                 (rd_acc & ~wr_acc) ? count_q - 1'b1 : count_q;
      // Set wins over clear when both happen in one cycle.
      ovf_d    = (write_en & full) | (ovf_q & ~clear_err);
      udf_d    = (read_en & empty) | (udf_q & ~clear_err);
      dout_d   = rd_acc ? ram_rdata : dout_q;
      valid_d  = rd_acc;
   end

   always_ff @(posedge clk1) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // FWFT exposes the head word directly; registered mode shows the popped word.
   assign data_out = FWFT ? ram_rdata : dout_q;
   assign valid    = FWFT ? ~empty : valid_q;
endmodule
